seg_scroll_ctrl: RTL

SEG_SCROLL_CTRL -- requirements
Module: seg_scroll_ctrl

---
 rtl/seg_ctrl_pkg.sv | 12 +
 rtl/seg_tick_gen.sv | 27 ++
 rtl/seg_scroll_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seg_ctrl_pkg.sv
// Shared types and default constants for the scrolling two-digit hex display controller.
package seg_ctrl_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SCROLL = 1'b1
    } seg_state_t;

    localparam int unsigned DEPTH_DEF    = 8;
    localparam int unsigned TICK_DIV_DEF = 50000;

endpackage

// File: rtl/seg_tick_gen.sv
// Scroll-rate divider: counts 0..TICK_DIV-1 while enabled and flags the last count as a step.
module seg_tick_gen #(
    parameter int unsigned TICK_DIV = seg_ctrl_pkg::TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam int unsigned   TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign step = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Loads a hex-nibble message, then scrolls it two digits at a time across a dual 7-seg display.
module seg_scroll_ctrl
    import seg_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       loop_i,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    input  logic [3:0] wr_data_i,
    input  logic       wr_last_i,
    output logic [3:0] hex1_data_o,
    output logic [3:0] hex0_data_o,
    output logic       blank_o,
    output logic       busy_o
);

    localparam int unsigned   IW      = $clog2(DEPTH);
    localparam int unsigned   CW      = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    seg_state_t    state;
    logic [CW-1:0] count;
    logic [CW-1:0] len;
    logic [CW-1:0] pos;
    logic [3:0]    mem [DEPTH];

    logic          accept;
    logic          finish;
    logic          step;
    logic          last_step;
    logic          advance;
    logic [CW-1:0] count_inc;
    logic [CW-1:0] load_len;
    logic [CW-1:0] tgt_pos;
    logic [CW-1:0] tgt_pos_inc;
    logic [CW-1:0] nbr_pos;
    logic [3:0]    rd1;
    logic [3:0]    rd0;

    assign wr_ready_o = (state == ST_IDLE) & ~clear_i;
    assign accept     = wr_valid_i & wr_ready_o;
    assign count_inc  = count + 1'b1;

    seg_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear_i | (state != ST_SCROLL)),
        .en   (state == ST_SCROLL),
        .step (step)
    );

    // Digits are loaded from the position the display moves to next; the beat being
    // written this cycle is forwarded so a message is visible on its first SCROLL cycle.
    always_comb begin
        finish    = accept & (wr_last_i | (count_inc == DEPTH_C));
        last_step = (state == ST_SCROLL) & step & (pos == len - 1'b1);
        advance   = (state == ST_SCROLL) & step & ~(last_step & ~loop_i);
        load_len  = finish ? count_inc : len;
        if (finish || last_step) begin
            tgt_pos = '0;
        end else begin
            tgt_pos = pos + 1'b1;
        end
        tgt_pos_inc = tgt_pos + 1'b1;
        nbr_pos     = (tgt_pos_inc == load_len) ? '0 : tgt_pos_inc;
        rd1         = mem[tgt_pos[IW-1:0]];
        rd0         = mem[nbr_pos[IW-1:0]];
        if (accept && (count == tgt_pos)) begin
            rd1 = wr_data_i;
        end
        if (accept && (count == nbr_pos)) begin
            rd0 = wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[count[IW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            len         <= '0;
            pos         <= '0;
            hex1_data_o <= '0;
            hex0_data_o <= '0;
            blank_o     <= 1'b1;
            busy_o      <= 1'b0;
        end else if (clear_i) begin
            state       <= ST_IDLE;
            count       <= '0;
            len         <= '0;
            pos         <= '0;
            hex1_data_o <= '0;
            hex0_data_o <= '0;
            blank_o     <= 1'b1;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        count <= count_inc;
                        if (finish) begin
                            state       <= ST_SCROLL;
                            len         <= count_inc;
                            pos         <= '0;
                            hex1_data_o <= rd1;
                            hex0_data_o <= rd0;
                            blank_o     <= 1'b0;
                            busy_o      <= 1'b1;
                        end
                    end
                end
                ST_SCROLL: begin
                    if (advance) begin
                        pos         <= tgt_pos;
                        hex1_data_o <= rd1;
                        hex0_data_o <= rd0;
                    end else if (last_step) begin
                        state       <= ST_IDLE;
                        count       <= '0;
                        pos         <= '0;
                        hex1_data_o <= '0;
                        hex0_data_o <= '0;
                        blank_o     <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
